// File: rtl/led_pkg.sv
// Shared constants and types for the LED-string frame store and serializer.
package led_pkg;

    localparam int NUM_LEDS     = 144;
    localparam int BITS_PER_LED = 24;
    localparam int FRAME_BITS   = NUM_LEDS * BITS_PER_LED;
    localparam int FRAME_IDX_W  = $clog2(FRAME_BITS);
    localparam int ADDR_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        DONE  = 2'd2
    } latch_state_t;

    // LED 0 sits in the top slice so it is shifted out first.
    function automatic logic [FRAME_IDX_W-1:0] led_top_bit(input logic [ADDR_W-1:0] idx);
        logic [FRAME_IDX_W-1:0] offset;
        offset = FRAME_IDX_W'(idx) * FRAME_IDX_W'(BITS_PER_LED);
        return FRAME_IDX_W'(FRAME_BITS - 1) - offset;
    endfunction

endpackage

// File: rtl/latch_timer.sv
// Times the WS2812 latch (reset-low) window and flags the edge on which the
// front buffer may be refreshed.
module latch_timer
    import led_pkg::*;
#(
    parameter int RESET_CYCLES = 3840
) (
    input  logic clk,
    input  logic rst,
    input  logic update_bits,
    output logic reset_done,
    output logic copy_strobe
);

    localparam int              CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RESET_CYCLES - 1);

    latch_state_t     r_state;
    latch_state_t     w_next_state;
    logic [CNT_W-1:0] r_count;
    logic             r_reset_done;
    logic             w_copy;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; the copy edge is the one that leaves LATCH on a full window.
    always_comb begin
        w_next_state = r_state;
        w_copy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (update_bits) begin
                    w_next_state = LATCH;
                end
            end
            LATCH: begin
                if (!update_bits) begin
                    w_next_state = IDLE;
                end else if (r_count == LAST) begin
                    w_next_state = DONE;
                    w_copy       = 1'b1;
                end
            end
            DONE: begin
                if (!update_bits) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Window counter runs only while staying in LATCH, so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == LATCH && w_next_state == LATCH) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= '0;
        end
    end

    // Registered completion flag, high for the whole DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reset_done <= 1'b0;
        end else begin
            r_reset_done <= (w_next_state == DONE);
        end
    end

    assign reset_done  = r_reset_done;
    assign copy_strobe = w_copy;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered LED frame store: pixels land in the back buffer and are
// published to the serializer-facing front buffer at the end of a latch window.
module frame_buffer
    import led_pkg::*;
#(
    parameter int RESET_CYCLES = 3840
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [BITS_PER_LED-1:0] wr_data,
    input  logic                    commit,
    input  logic                    update_bits,
    output logic [FRAME_BITS-1:0]   rgb_string,
    output logic                    reset_done,
    output logic                    commit_pending,
    output logic                    commit_done
);

    logic [FRAME_BITS-1:0]  r_front;
    logic [FRAME_BITS-1:0]  r_back;
    logic                   r_commit_pending;
    logic                   r_commit_done;
    logic                   w_copy_strobe;
    logic                   w_publish;
    logic                   w_wr_hit;
    logic [FRAME_IDX_W-1:0] w_wr_top;

    latch_timer #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_latch_timer (
        .clk         (clk),
        .rst         (rst),
        .update_bits (update_bits),
        .reset_done  (reset_done),
        .copy_strobe (w_copy_strobe)
    );

    assign w_publish = w_copy_strobe & r_commit_pending;
    assign w_wr_hit  = wr_en & (wr_addr < ADDR_W'(NUM_LEDS));
    assign w_wr_top  = led_top_bit(wr_addr);

    // Front buffer only changes on a publishing copy edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_front <= '0;
        end else if (w_publish) begin
            r_front <= r_back;
        end
    end

    // Back buffer write; the copy above reads the pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_back <= '0;
        end else if (w_wr_hit) begin
            r_back[w_wr_top -: BITS_PER_LED] <= wr_data;
        end
    end

    // Pending flag; a commit on the copy edge re-arms it for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_pending <= 1'b0;
        end else if (w_copy_strobe) begin
            r_commit_pending <= commit;
        end else begin
            r_commit_pending <= r_commit_pending | commit;
        end
    end

    // One-cycle pulse aligned with the front buffer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_done <= 1'b0;
        end else begin
            r_commit_done <= w_publish;
        end
    end

    assign rgb_string     = r_front;
    assign commit_pending = r_commit_pending;
    assign commit_done    = r_commit_done;

endmodule
